// File: rtl/fp_div_param_if.sv
// Handshake and data bundle for the parameterised floating-point divider.
// master: request side (drives enable/start/operands); slave: the divider.
interface fp_div_param_if #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
);
   localparam int unsigned W = 1 + EXP_W + MAN_W;

   logic         enable;
   logic         start;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [W-1:0] q;
   logic         busy;
   logic         done;
   logic         stall;
   logic [4:0]   flags;

   modport master (
      output enable, start, a, b,
      input  q, busy, done, stall, flags
   );

   modport slave (
      input  enable, start, a, b,
      output q, busy, done, stall, flags
   );
endinterface

// File: rtl/fp_div_param.sv
// Multi-cycle IEEE-754-format divider, one restoring-division quotient bit per cycle,
// round-to-nearest-even, subnormals flushed to signed zero.
// Define FP_DIV_FLAGS_EN to build the exception flag logic; otherwise flags read as 0.
module fp_div_param #(
   parameter int unsigned EXP_W = 8,
   parameter int unsigned MAN_W = 23
) (
   input logic           clk,
   input logic           rst,
   fp_div_param_if.slave bus
);
   localparam int unsigned W  = 1 + EXP_W + MAN_W;
   localparam int unsigned QW = MAN_W + 3;   // mantissa incl. hidden bit, guard, round
   localparam int unsigned EW = EXP_W + 2;   // signed working exponent
   localparam int unsigned CW = $clog2(QW);

   localparam logic [EW-1:0] EXP_BIAS = EW'((1 << (EXP_W - 1)) - 1);
   localparam logic [EW-1:0] EXP_MAX  = EW'((1 << EXP_W) - 1);
   localparam logic [W-1:0]  QNAN     = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W - 1){1'b0}}};

   localparam logic [2:0] StIdle   = 3'd0;
   localparam logic [2:0] StUnpack = 3'd1;
   localparam logic [2:0] StIter   = 3'd2;
   localparam logic [2:0] StRound  = 3'd3;
   localparam logic [2:0] StDone   = 3'd4;

   logic [2:0]       state_q, state_d;
   logic [W-1:0]     a_q, a_d, b_q, b_d, q_q, q_d;
   logic             sign_q, sign_d;
   logic [EW-1:0]    exp_q, exp_d;
   logic [MAN_W:0]   div_q, div_d;
   logic [MAN_W+1:0] rem_q, rem_d;
   logic [QW-1:0]    quo_q, quo_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic             busy_q, busy_d, done_q, done_d;
`ifdef FP_DIV_FLAGS_EN
   logic [4:0]       flags_q, flags_d, spec_flags, rnd_flags;
`endif

   // Operand fields of the captured request
   logic [EXP_W-1:0] ea, eb;
   logic [MAN_W-1:0] fa, fb;
   logic             a_zero, b_zero, a_inf, b_inf, a_nan, b_nan, sign_ab;
   logic [EW-1:0]    exp_un;

   assign ea      = a_q[W-2 -: EXP_W];
   assign eb      = b_q[W-2 -: EXP_W];
   assign fa      = a_q[MAN_W-1:0];
   assign fb      = b_q[MAN_W-1:0];
   assign a_zero  = (ea == '0);
   assign b_zero  = (eb == '0);
   assign a_inf   = (ea == '1) && (fa == '0);
   assign b_inf   = (eb == '1) && (fb == '0);
   assign a_nan   = (ea == '1) && (fa != '0);
   assign b_nan   = (eb == '1) && (fb != '0);
   assign sign_ab = a_q[W-1] ^ b_q[W-1];
   assign exp_un  = {2'b00, ea} - {2'b00, eb} + EXP_BIAS;

   // Special-operand classification and its fixed result
   logic         special;
   logic [W-1:0] spec_res;

   always_comb begin
      special  = 1'b1;
      spec_res = {sign_ab, {(W - 1){1'b0}}};
`ifdef FP_DIV_FLAGS_EN
      spec_flags = '0;
`endif
      if (a_nan || b_nan) begin
         spec_res = QNAN;
      end else if ((a_zero && b_zero) || (a_inf && b_inf)) begin
         spec_res = QNAN;
`ifdef FP_DIV_FLAGS_EN
         spec_flags = 5'b10000;
`endif
      end else if (a_inf) begin
         spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
      end else if (b_inf) begin
         spec_res = {sign_ab, {(W - 1){1'b0}}};
      end else if (b_zero) begin
         spec_res = {sign_ab, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
         spec_flags = 5'b01000;
`endif
      end else if (a_zero) begin
         spec_res = {sign_ab, {(W - 1){1'b0}}};
      end else begin
         special = 1'b0;
      end
   end

   // One restoring-division step
   logic             rem_ge;
   logic [MAN_W+1:0] rem_sel, rem_next;

   assign rem_ge   = (rem_q >= {1'b0, div_q});
   assign rem_sel  = rem_ge ? (rem_q - {1'b0, div_q}) : rem_q;
   assign rem_next = rem_sel << 1;

   // Normalise by at most one bit, round to nearest even, pack or saturate
   logic             norm, rbit, sticky, rnd_up;
   logic [MAN_W:0]   man_pre;
   logic [MAN_W+1:0] man_sum;
   logic [MAN_W-1:0] frac;
   logic [EW-1:0]    exp_n, exp_fin;
   logic [W-1:0]     rnd_res;

   always_comb begin
      norm    = quo_q[QW-1];
      man_pre = norm ? quo_q[QW-1:2] : quo_q[QW-2:1];
      rbit    = norm ? quo_q[1] : quo_q[0];
      sticky  = (norm & quo_q[0]) | (rem_q != '0);
      exp_n   = exp_q - {{(EW - 1){1'b0}}, ~norm};
      rnd_up  = rbit & (sticky | man_pre[0]);
      man_sum = {1'b0, man_pre} + {{(MAN_W + 1){1'b0}}, rnd_up};
      // On carry the sum is exactly 10..0, so the shifted fraction is all zero
      frac    = man_sum[MAN_W+1] ? man_sum[MAN_W:1] : man_sum[MAN_W-1:0];
      exp_fin = exp_n + {{(EW - 1){1'b0}}, man_sum[MAN_W+1]};
      rnd_res = {sign_q, exp_fin[EXP_W-1:0], frac};
`ifdef FP_DIV_FLAGS_EN
      rnd_flags = {4'b0000, rbit | sticky};
`endif
      if (!exp_fin[EW-1] && (exp_fin >= EXP_MAX)) begin
         rnd_res = {sign_q, {EXP_W{1'b1}}, {MAN_W{1'b0}}};
`ifdef FP_DIV_FLAGS_EN
         rnd_flags = 5'b00101;
`endif
      end else if (exp_fin[EW-1] || (exp_fin == '0)) begin
         rnd_res = {sign_q, {(W - 1){1'b0}}};
`ifdef FP_DIV_FLAGS_EN
         rnd_flags = 5'b00011;
`endif
      end
   end

   // Next-state logic for the controller and datapath
   always_comb begin
      state_d = state_q;
      a_d     = a_q;
      b_d     = b_q;
      q_d     = q_q;
      sign_d  = sign_q;
      exp_d   = exp_q;
      div_d   = div_q;
      rem_d   = rem_q;
      quo_d   = quo_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = 1'b0;
`ifdef FP_DIV_FLAGS_EN
      flags_d = flags_q;
`endif
      case (state_q)
         StIdle: begin
            if (bus.start) begin
               a_d     = bus.a;
               b_d     = bus.b;
               busy_d  = 1'b1;
               state_d = StUnpack;
            end
         end
         StUnpack: begin
            sign_d  = sign_ab;
            exp_d   = exp_un;
            div_d   = {1'b1, fb};
            rem_d   = {2'b01, fa};
            quo_d   = '0;
            cnt_d   = '0;
            state_d = StIter;
            if (special) begin
               q_d     = spec_res;
               done_d  = 1'b1;
               state_d = StDone;
`ifdef FP_DIV_FLAGS_EN
               flags_d = spec_flags;
`endif
            end
         end
         StIter: begin
            rem_d = rem_next;
            quo_d = {quo_q[QW-2:0], rem_ge};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == CW'(QW - 1)) begin
               state_d = StRound;
            end
         end
         StRound: begin
            q_d     = rnd_res;
            done_d  = 1'b1;
            state_d = StDone;
`ifdef FP_DIV_FLAGS_EN
            flags_d = rnd_flags;
`endif
         end
         StDone: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
         default: begin
            busy_d  = 1'b0;
            state_d = StIdle;
         end
      endcase
   end

   // State register: reset wins over enable, enable low freezes everything
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         a_q     <= '0;
         b_q     <= '0;
         q_q     <= '0;
         sign_q  <= 1'b0;
         exp_q   <= '0;
         div_q   <= '0;
         rem_q   <= '0;
         quo_q   <= '0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
`ifdef FP_DIV_FLAGS_EN
         flags_q <= '0;
`endif
      end else if (bus.enable) begin
         state_q <= state_d;
         a_q     <= a_d;
         b_q     <= b_d;
         q_q     <= q_d;
         sign_q  <= sign_d;
         exp_q   <= exp_d;
         div_q   <= div_d;
         rem_q   <= rem_d;
         quo_q   <= quo_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
`ifdef FP_DIV_FLAGS_EN
         flags_q <= flags_d;
`endif
      end
   end

   assign bus.q     = q_q;
   assign bus.busy  = busy_q;
   assign bus.done  = done_q;
   assign bus.stall = bus.start & busy_q;
`ifdef FP_DIV_FLAGS_EN
   assign bus.flags = flags_q;
`else
   assign bus.flags = '0;
`endif
endmodule

// File: tb/tb_fp_div_param.sv
// Directed bench for fp_div_param: a single-precision instance and a half-precision
// instance, expected results queued at request time and compared on done.
// Flag expectations follow FP_DIV_FLAGS_EN (all zero when it is undefined).
module tb_fp_div_param;
`ifdef FP_DIV_FLAGS_EN
   localparam logic [4:0] FLAG_MASK = 5'b11111;
`else
   localparam logic [4:0] FLAG_MASK = 5'b00000;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        start_r, en_r, use_h;
   logic [31:0] a_r, b_r;

   always #5 clk = ~clk;

   fp_div_param_if #(.EXP_W(8), .MAN_W(23)) fbus ();
   fp_div_param_if #(.EXP_W(5), .MAN_W(10)) hbus ();

   assign fbus.enable = en_r;
   assign fbus.start  = start_r & ~use_h;
   assign fbus.a      = a_r;
   assign fbus.b      = b_r;
   assign hbus.enable = en_r;
   assign hbus.start  = start_r & use_h;
   assign hbus.a      = a_r[15:0];
   assign hbus.b      = b_r[15:0];

   fp_div_param #(.EXP_W(8), .MAN_W(23)) dut_f (
      .clk (clk),
      .rst (rst),
      .bus (fbus)
   );

   fp_div_param #(.EXP_W(5), .MAN_W(10)) dut_h (
      .clk (clk),
      .rst (rst),
      .bus (hbus)
   );

   logic [31:0] o_q;
   logic [4:0]  o_flags;
   logic        o_busy, o_done, o_stall;

   // Observe whichever instance is currently under test
   always_comb begin
      if (use_h) begin
         o_q     = {16'h0000, hbus.q};
         o_flags = hbus.flags;
         o_busy  = hbus.busy;
         o_done  = hbus.done;
         o_stall = hbus.stall;
      end else begin
         o_q     = fbus.q;
         o_flags = fbus.flags;
         o_busy  = fbus.busy;
         o_done  = fbus.done;
         o_stall = fbus.stall;
      end
   end

   typedef struct packed {
      logic [31:0] q;
      logic [4:0]  f;
   } exp_t;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
      n_tests++;
      assert (obs === exp_v)
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [31:0] eq, input logic [4:0] ef);
      exp_t e;
      e.q = eq;
      e.f = ef & FLAG_MASK;
      sb.push_back(e);
   endtask

   task automatic pop_check(input string tag);
      exp_t e;
      check({tag, " result pending"}, 64'(sb.size() != 0), 64'd1);
      if (sb.size() != 0) begin
         e = sb.pop_front();
         check({tag, " q"}, 64'(o_q), 64'(e.q));
         check({tag, " flags"}, 64'(o_flags), 64'(e.f));
      end
   endtask

   // One request; optional enable-low window and a held done cycle
   task automatic run_op(input string tag, input logic [31:0] ta, input logic [31:0] tbv,
                         input logic [31:0] eq, input logic [4:0] ef, input int lat,
                         input int frz_at, input int frz_len, input bit hold);
      int          cyc;
      int          bsy;
      logic [31:0] q_prev;
      a_r     = ta;
      b_r     = tbv;
      en_r    = 1'b1;
      start_r = 1'b1;
      push_exp(eq, ef);
      tick();
      start_r = 1'b0;
      cyc     = 1;
      bsy     = 0;
      q_prev  = o_q;
      while (o_done !== 1'b1 && cyc < 200) begin
         if (o_busy === 1'b1) bsy++;
         en_r = (cyc >= frz_at && cyc < frz_at + frz_len) ? 1'b0 : 1'b1;
         tick();
         cyc++;
         if (cyc > frz_at && cyc <= frz_at + frz_len) begin
            check({tag, " q frozen"}, 64'(o_q), 64'(q_prev));
         end
      end
      en_r = 1'b1;
      if (o_busy === 1'b1) bsy++;
      check({tag, " latency"}, 64'(cyc), 64'(lat + frz_len));
      check({tag, " busy cycles"}, 64'(bsy), 64'(lat + frz_len));
      pop_check(tag);
      if (hold) begin
         en_r = 1'b0;
         tick();
         check({tag, " done held"}, 64'({o_done, o_busy}), 64'(2'b11));
         en_r = 1'b1;
      end
      tick();
      check({tag, " done clear"}, 64'({o_done, o_busy}), 64'(2'b00));
   endtask

   initial begin
      int cyc;
      int nst;
      int ndone;
      use_h   = 1'b0;
      rst     = 1'b1;
      start_r = 1'b0;
      en_r    = 1'b1;
      a_r     = '0;
      b_r     = '0;
      repeat (3) tick();
      check("reset q", 64'(fbus.q), 64'd0);
      check("reset flags", 64'(fbus.flags), 64'd0);
      check("reset busy/done", 64'({fbus.busy, fbus.done, hbus.busy, hbus.done}), 64'd0);
      check("reset half q", 64'(hbus.q), 64'd0);
      rst = 1'b0;
      tick();

      run_op("basic", 32'hc396d200, 32'hc0100000, 32'h43061000, 5'b00000, 29, 0, 0, 1'b0);

      // Request held high across a busy divider, then a second one queued behind it
      a_r     = 32'h42e88000;
      b_r     = 32'h41780000;
      start_r = 1'b1;
      push_exp(32'h40f00000, 5'b00000);
      tick();
      a_r = 32'h40ae0000;
      b_r = 32'hbec00000;
      push_exp(32'hc1680000, 5'b00000);
      cyc = 1;
      nst = 0;
      while (o_done !== 1'b1 && cyc < 200) begin
         if (o_stall !== 1'b1) nst++;
         tick();
         cyc++;
      end
      if (o_stall !== 1'b1) nst++;
      check("b2b first latency", 64'(cyc), 64'd29);
      check("b2b stall misses", 64'(nst), 64'd0);
      pop_check("b2b first");
      tick();
      check("b2b idle gap", 64'({o_busy, o_done, o_stall}), 64'(3'b000));
      tick();
      start_r = 1'b0;
      check("b2b second accepted", 64'(o_busy), 64'd1);
      cyc = 1;
      while (o_done !== 1'b1 && cyc < 200) begin
         tick();
         cyc++;
      end
      check("b2b second latency", 64'(cyc), 64'd29);
      pop_check("b2b second");
      tick();

      run_op("x/0", 32'h3f800000, 32'h00000000, 32'h7f800000, 5'b01000, 2, 0, 0, 1'b0);
      run_op("0/0", 32'h00000000, 32'h00000000, 32'h7fc00000, 5'b10000, 2, 0, 0, 1'b0);
      run_op("1/3 freeze", 32'h3f800000, 32'h40400000, 32'h3eaaaaab, 5'b00001, 29, 10, 5,
             1'b1);
      run_op("2/3", 32'h40000000, 32'h40400000, 32'h3f2aaaab, 5'b00001, 29, 0, 0, 1'b0);
      run_op("-1/3", 32'hbf800000, 32'h40400000, 32'hbeaaaaab, 5'b00001, 29, 0, 0, 1'b0);
      run_op("overflow", 32'h7f000000, 32'h3e800000, 32'h7f800000, 5'b00101, 29, 0, 0, 1'b0);
      run_op("underflow", 32'h80800000, 32'h4b000000, 32'h80000000, 5'b00011, 29, 0, 0,
             1'b0);
      run_op("nan in", 32'h7fc12345, 32'h3f800000, 32'h7fc00000, 5'b00000, 2, 0, 0, 1'b0);
      run_op("inf/inf", 32'h7f800000, 32'hff800000, 32'h7fc00000, 5'b10000, 2, 0, 0, 1'b0);
      run_op("inf/x", 32'hff800000, 32'h40000000, 32'hff800000, 5'b00000, 2, 0, 0, 1'b0);
      run_op("x/inf", 32'h40000000, 32'hff800000, 32'h80000000, 5'b00000, 2, 0, 0, 1'b0);
      run_op("0/x", 32'h80000000, 32'h40000000, 32'h80000000, 5'b00000, 2, 0, 0, 1'b0);
      run_op("sub/x", 32'h00000001, 32'h3f800000, 32'h00000000, 5'b00000, 2, 0, 0, 1'b0);
      run_op("7.5 again", 32'h42e88000, 32'h41780000, 32'h40f00000, 5'b00000, 29, 0, 0, 1'b0);

      // Reset mid-division, with enable low to show reset ignores it
      a_r     = 32'h3f800000;
      b_r     = 32'h40400000;
      start_r = 1'b1;
      tick();
      start_r = 1'b0;
      repeat (9) tick();
      en_r = 1'b0;
      rst  = 1'b1;
      tick();
      rst  = 1'b0;
      en_r = 1'b1;
      check("mid rst busy/done", 64'({o_busy, o_done}), 64'(2'b00));
      check("mid rst q", 64'(o_q), 64'd0);
      check("mid rst flags", 64'(o_flags), 64'd0);
      ndone = 0;
      repeat (40) begin
         tick();
         if (o_done === 1'b1) ndone++;
      end
      check("abandoned no done", 64'(ndone), 64'd0);

      // Reset and start together: reset wins
      start_r = 1'b1;
      rst     = 1'b1;
      tick();
      rst     = 1'b0;
      start_r = 1'b0;
      check("rst over start", 64'(o_busy), 64'd0);

      use_h = 1'b1;
      tick();
      run_op("half 3/2", 32'h00004200, 32'h00004000, 32'h00003e00, 5'b00000, 16, 0, 0, 1'b0);
      run_op("half x/sub", 32'h00007bff, 32'h00000001, 32'h00007c00, 5'b01000, 2, 0, 0, 1'b0);

      check("scoreboard drained", 64'(sb.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
